// File: rtl/ibex_fetch_skid_stage.sv
// rtl/ibex_fetch_skid_stage.sv - registered fetch output stage with optional two-entry skid buffer
module ibex_fetch_skid_stage #(
  parameter bit SkidEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic [31:0] in_addr_i,
  input  logic        in_err_i,
  input  logic        in_err_plus2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_pc_next_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  output logic        busy_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] pc_next;
    logic        is_compressed;
    logic        err;
    logic        err_plus2;
  } entry_t;

  entry_t in_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_fire, out_fire;

  // Decode is done once at capture so the ID-facing outputs come straight from flops.
  always_comb begin
    in_entry               = '0;
    in_entry.is_compressed = (in_rdata_i[1:0] != 2'b11);
    in_entry.instr         = in_entry.is_compressed ? {16'h0000, in_rdata_i[15:0]} : in_rdata_i;
    in_entry.addr          = in_addr_i;
    in_entry.pc_next       = in_addr_i + (in_entry.is_compressed ? 32'd2 : 32'd4);
    in_entry.err           = in_err_i;
    in_entry.err_plus2     = in_err_plus2_i & ~in_entry.is_compressed;
  end

  assign in_ready_o = SkidEn ? ~skid_valid_q : (~main_valid_q | out_ready_i);
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = main_valid_q & out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SkidEn && skid_valid_q) begin
      // in_ready_o is low here, so only the skid-to-main move can happen.
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_d = in_entry;
      end
    end else if (SkidEn && in_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o         = main_valid_q;
  assign out_instr_o         = main_q.instr;
  assign out_addr_o          = main_q.addr;
  assign out_pc_next_o       = main_q.pc_next;
  assign out_is_compressed_o = main_q.is_compressed;
  assign out_err_o           = main_q.err;
  assign out_err_plus2_o     = main_q.err_plus2;
  assign busy_o              = main_valid_q | skid_valid_q;

  a_in_addr_aligned : assert property (@(posedge clk_i) disable iff (rst_i)
    in_fire |-> !in_addr_i[0]);

  a_no_fire_skid_full : assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_fire && skid_valid_q));

  a_out_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(out_instr_o) && $stable(out_addr_o) && $stable(out_pc_next_o) &&
       $stable(out_is_compressed_o) && $stable(out_err_o) && $stable(out_err_plus2_o)));

endmodule
